// File: rtl/tcam_match_drain.sv
// Drains a captured TCAM match vector: reports hit/popcount, then streams every
// matching address in ascending order over a valid/ready port, ending with a done pulse.
module tcam_match_drain #(
  parameter int address_size = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [(1<<address_size)-1:0]  matched,
  input  logic                          load,
  input  logic                          flush,
  input  logic                          out_ready,
  output logic [address_size-1:0]       out_address,
  output logic                          out_valid,
  output logic                          hit,
  output logic [address_size:0]         count,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    fsm_state
);

  localparam int width = 1 << address_size;

  // Handshake: a transfer happens at a rising edge where out_valid & out_ready are both
  // high; out_address is held stable while out_valid=1 and out_ready=0.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [width-1:0]        pending_q, pending_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic                    valid_q, valid_d;
  logic                    hit_q, hit_d;
  logic [address_size:0]   count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [width-1:0]        remaining;

  function automatic logic [address_size-1:0] lowest_index(input logic [width-1:0] v);
    logic [address_size-1:0] idx;
    idx = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (v[i]) idx = address_size'(i);
    end
    return idx;
  endfunction

  function automatic logic [address_size:0] popcount(input logic [width-1:0] v);
    logic [address_size:0] c;
    c = '0;
    for (int i = 0; i < width; i++) begin
      c = c + (address_size+1)'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    hit_d     = hit_q;
    count_d   = count_q;
    remaining = pending_q & ~({{(width-1){1'b0}}, 1'b1} << addr_q);

    case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = matched;
          hit_d     = |matched;
          count_d   = popcount(matched);
          if (|matched) begin
            addr_d  = lowest_index(matched);
            valid_d = 1'b1;
            state_d = SCAN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (valid_q && out_ready) begin
          pending_d = remaining;
          if (|remaining) begin
            addr_d = lowest_index(remaining);
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over a same-edge load or handshake; the captured hit/count survive.
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
      valid_d   = 1'b0;
      addr_d    = addr_q;
      hit_d     = hit_q;
      count_d   = count_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_address = addr_q;
  assign out_valid   = valid_q;
  assign hit         = hit_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fsm_state   = state_q;

endmodule

// File: doc/tcam_match_drain.md
Name: tcam_match_drain

Overview:
- Consumer for the ternary CAM's registered one-hot-per-entry match vector.
- On load, snapshots the vector, reports hit/count, then streams every matching address out in ascending order, one per accepted handshake.
- Sits between the CAM search port and the lookup result FIFO/controller.

Parameters:
- address_size, 4, CAM address width; match vector width is 1 << address_size.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- matched  input  1<<address_size  match vector from the CAM; bit i set = entry i matched.
- load  input  1  capture request; honoured only in IDLE.
- flush  input  1  synchronous abort to IDLE.
- out_ready  input  1  downstream accepts out_address.
- out_address  output  address_size  current matching address.
- out_valid  output  1  out_address is valid.
- hit  output  1  captured vector had at least one bit set.
- count  output  address_size+1  popcount of captured vector (0..2^address_size).
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse at end of drain.

Behaviour:
- All outputs and state are registered.
- reset (async, any time, including mid-drain) forces:
  - state IDLE; internal pending vector 0;
  - out_address 0; out_valid 0; hit 0; count 0; busy 0; done 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - load=1 at a clock edge: pending <= matched; hit <= |matched; count <= popcount(matched).
  - If matched != 0: out_address <= index of lowest set bit; out_valid <= 1; state SCAN. First out_valid appears one cycle after load.
  - If matched == 0: state DONE directly; out_valid stays 0.
- SCAN:
  - out_valid=1. out_address is stable while out_ready=0.
  - Handshake = out_valid & out_ready at an edge. On handshake, clear the current bit in pending.
    - If remaining pending != 0: out_address <= next lowest set index (back-to-back, one address per cycle with out_ready held high).
    - Else: out_valid <= 0; state DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SCAN and DONE, 0 in IDLE.
- hit and count hold their captured values until the next accepted load or reset. flush does not clear them.
- load in SCAN or DONE is ignored. The snapshot is not disturbed, and matched changing mid-drain has no effect.
- flush=1 at any edge, in any state:
  - pending <= 0; out_valid <= 0; state IDLE.
  - No done pulse.
  - flush takes priority over a simultaneous handshake or load.
- Address order is strictly ascending; index 0 has the highest priority.
- Full vector (all 2^address_size bits set): emits every address 0..2^address_size-1. count = 2^address_size, which needs the extra count bit.
- Maximum drain length = count cycles of handshakes + 1 DONE cycle.

Test Plan (address_size=4):
- Reset mid-SCAN (assert while out_valid=1) -> all outputs 0 immediately, without waiting for a clock edge; state IDLE after release.
- matched=16'h8421, load, out_ready=1 -> out_address 0,5,10,15 on consecutive cycles; count=4; hit=1; done pulses the cycle after 15 is accepted.
- matched=16'h0000, load -> out_valid never asserts; hit=0; count=0; done pulses one cycle after load.
- matched=16'hFFFF, load, out_ready toggling 1/0 -> all 16 addresses 0..15 in order; out_address held during ready=0 cycles; count=16.
- matched=16'h0030, load; during SCAN, load with matched=16'h0001 -> output only 4,5; the second load is ignored.
- matched=16'h00F0, load, accept address 4, then flush -> out_valid=0, busy=0 next cycle; no done pulse; count stays 4.
